// File: rtl/spi_dac_multi.sv
// spi_dac_multi: sample-rate divider plus a multi-channel MCP49x1 SPI DAC driver with a common DAC_LD strobe
// Ports: CLOCK_50/RST_N clock and sync active-low reset; EN runs divider; DATA packed samples (ch k at [k*DATA_W +: DATA_W]);
//        CLR_OVR clears OVERRUN; DAC_SDI/DAC_SCK/DAC_CS/DAC_LD to the DACs; TICK sample strobe; BUSY frame active; OVERRUN sticky drop flag
module spi_dac_multi #(
  parameter int NCH    = 2,
  parameter int DATA_W = 10,
  parameter int DIV    = 5000,
  parameter bit BUF    = 1'b0,
  parameter bit GA_N   = 1'b1
) (
  input  logic                    CLOCK_50,
  input  logic                    RST_N,
  input  logic                    EN,
  input  logic [NCH*DATA_W-1:0]   DATA,
  input  logic                    CLR_OVR,
  output logic                    DAC_SDI,
  output logic [NCH-1:0]          DAC_CS,
  output logic                    DAC_SCK,
  output logic                    DAC_LD,
  output logic                    TICK,
  output logic                    BUSY,
  output logic                    OVERRUN
);
  localparam int DW = $clog2(DIV);
  localparam logic [2:0] S_IDLE = 3'd0, S_LOAD = 3'd1, S_SHIFT = 3'd2, S_GAP = 3'd3, S_LDAC = 3'd4;
  logic [DW-1:0]         r_div;
  logic                  r_tick;
  logic                  r_ovr;
  logic [2:0]            r_state;
  logic [4:0]            r_cnt;
  logic [1:0]            r_ch;
  logic [NCH*DATA_W-1:0] r_data;
  logic [DATA_W-1:0]     w_sample;
  logic [15:0]           w_word;
  logic                  w_shift;
  logic                  w_wrap;
  assign w_wrap   = r_div == DW'(DIV - 1);
  assign w_sample = DATA_W'(r_data >> (DATA_W * int'(r_ch)));
  assign w_word   = {1'b0, BUF, GA_N, 1'b1, 12'(w_sample) << (12 - DATA_W)};
  assign w_shift  = r_state == S_SHIFT;
  assign DAC_CS   = w_shift ? ~(NCH'(1) << r_ch) : '1;
  assign DAC_SCK  = w_shift & r_cnt[0];
  // bit index 15-p/2 is the inverse of p[4:1]; it only changes on even phases
  assign DAC_SDI  = w_shift & w_word[~r_cnt[4:1]];
  assign DAC_LD   = r_state != S_LDAC;
  assign TICK     = r_tick;
  assign BUSY     = r_state != S_IDLE;
  assign OVERRUN  = r_ovr;
  always_ff @(posedge CLOCK_50) begin
    if (!RST_N) begin
      r_div   <= '0;
      r_tick  <= 1'b0;
      r_ovr   <= 1'b0;
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_ch    <= '0;
      r_data  <= '0;
    end else begin
      r_div  <= (!EN || w_wrap) ? '0 : r_div + DW'(1);
      r_tick <= EN && w_wrap;
      // a new overrun beats a simultaneous clear
      r_ovr  <= (r_tick && r_state != S_IDLE) || (r_ovr && !CLR_OVR);
      case (r_state)
        S_IDLE: if (r_tick) r_state <= S_LOAD;
        S_LOAD: begin
          r_data  <= DATA;
          r_ch    <= '0;
          r_cnt   <= '0;
          r_state <= S_SHIFT;
        end
        S_SHIFT: begin
          r_cnt <= r_cnt + 5'd1;
          if (&r_cnt) r_state <= S_GAP;
        end
        S_GAP: begin
          r_cnt <= r_cnt[0] ? '0 : r_cnt + 5'd1;
          if (r_cnt[0]) begin
            r_state <= r_ch == 2'(NCH - 1) ? S_LDAC : S_SHIFT;
            r_ch    <= r_ch == 2'(NCH - 1) ? r_ch : r_ch + 2'd1;
          end
        end
        S_LDAC: begin
          r_cnt <= r_cnt[0] ? '0 : r_cnt + 5'd1;
          if (r_cnt[0]) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_dac_multi.sv
// tb_spi_dac_multi: directed/randomized bench for spi_dac_multi with a frame-level reference model
module tb_spi_dac_multi;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n, en1, en2, clr1, clr2, sel;
  logic [19:0] data1;
  logic [15:0] data2;
  logic sdi1, sck1, ld1, tick1, busy1, ovr1;
  logic sdi2, sck2, ld2, tick2, busy2, ovr2;
  logic [1:0] cs1, cs2;
  logic m_sdi, m_sck, m_ld, m_tick, m_busy;
  logic [1:0] m_cs;
  int vectors = 0;
  int miscompares = 0;
  spi_dac_multi #(.NCH(2), .DATA_W(10), .DIV(100)) u1 (
    .CLOCK_50(clk), .RST_N(rst_n), .EN(en1), .DATA(data1), .CLR_OVR(clr1),
    .DAC_SDI(sdi1), .DAC_CS(cs1), .DAC_SCK(sck1), .DAC_LD(ld1),
    .TICK(tick1), .BUSY(busy1), .OVERRUN(ovr1));
  spi_dac_multi #(.NCH(2), .DATA_W(8), .DIV(60)) u2 (
    .CLOCK_50(clk), .RST_N(rst_n), .EN(en2), .DATA(data2), .CLR_OVR(clr2),
    .DAC_SDI(sdi2), .DAC_CS(cs2), .DAC_SCK(sck2), .DAC_LD(ld2),
    .TICK(tick2), .BUSY(busy2), .OVERRUN(ovr2));
  assign m_sdi  = sel ? sdi2 : sdi1;
  assign m_sck  = sel ? sck2 : sck1;
  assign m_ld   = sel ? ld2 : ld1;
  assign m_tick = sel ? tick2 : tick1;
  assign m_busy = sel ? busy2 : busy1;
  assign m_cs   = sel ? cs2 : cs1;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic wait_tick(input int bound, output bit ok);
    int i;
    ok = 1'b0;
    i = 0;
    while (!ok && i < bound) begin
      step();
      ok = m_tick;
      i++;
    end
  endtask
  function automatic logic [15:0] model_word(input int w, input int s);
    return 16'(32'h3000 + ((s % (1 << w)) << (12 - w)));
  endfunction
  task automatic frame(input string tag, input logic sel_i, input int w, input int s0, input int s1,
                       input bit chg, input bit drop, input bit clr_tick);
    logic [15:0] exp0, exp1, got0, got1;
    int busy_n, cs0_n, cs1_n, both_n, ld_n, first_cs, cs0_last, cs1_first;
    logic psck;
    bit ok;
    sel = sel_i;
    if (sel_i) data2 = {8'(s1), 8'(s0)};
    else data1 = {10'(s1), 10'(s0)};
    exp0 = model_word(w, s0);
    exp1 = model_word(w, s1);
    wait_tick(200, ok);
    check({tag, " tick seen"}, 32'(ok), 32'd1);
    {busy_n, cs0_n, cs1_n, both_n, ld_n} = '0;
    first_cs = -1;
    cs0_last = -1;
    cs1_first = -1;
    got0 = '0;
    got1 = '0;
    psck = 1'b0;
    for (int n = 1; n <= 80; n++) begin
      step();
      if (m_busy) busy_n++;
      if (!m_ld) ld_n++;
      if (m_cs != 2'b11 && first_cs < 0) first_cs = n;
      if (m_cs == 2'b10) begin cs0_n++; cs0_last = n; end
      if (m_cs == 2'b01) begin cs1_n++; if (cs1_first < 0) cs1_first = n; end
      if (m_cs == 2'b00) both_n++;
      if (m_sck && !psck) begin
        if (m_cs == 2'b10) got0 = {got0[14:0], m_sdi};
        else if (m_cs == 2'b01) got1 = {got1[14:0], m_sdi};
      end
      psck = m_sck;
      if (chg && n == 2) begin data1 = 20'($urandom); data2 = 16'($urandom); end
      if (drop && n == 5) en1 = 1'b0;
      clr2 = clr_tick && m_tick;
    end
    clr2 = 1'b0;
    check({tag, " word ch0"}, 32'(got0), 32'(exp0));
    check({tag, " word ch1"}, 32'(got1), 32'(exp1));
    check({tag, " cs0 low cycles"}, 32'(cs0_n), 32'd32);
    check({tag, " cs1 low cycles"}, 32'(cs1_n), 32'd32);
    check({tag, " both cs low"}, 32'(both_n), 32'd0);
    check({tag, " first cs latency"}, 32'(first_cs), 32'd2);
    check({tag, " gap"}, 32'(cs1_first - cs0_last - 1), 32'd2);
    check({tag, " ld low cycles"}, 32'(ld_n), 32'd2);
    check({tag, " busy cycles"}, 32'(busy_n), 32'd71);
  endtask
  initial begin
    int t_at, ticks;
    bit ok;
    rst_n = 1'b0;
    en1 = 1'b1;
    en2 = 1'b0;
    clr1 = 1'b0;
    clr2 = 1'b0;
    sel = 1'b0;
    data1 = '0;
    data2 = '0;
    repeat (3) step();
    check("reset cs", 32'(cs1), 32'h3);
    check("reset sck", 32'(sck1), 32'd0);
    check("reset sdi", 32'(sdi1), 32'd0);
    check("reset ld", 32'(ld1), 32'd1);
    check("reset tick", 32'(tick1), 32'd0);
    check("reset busy", 32'(busy1), 32'd0);
    check("reset ovr", 32'(ovr1), 32'd0);
    rst_n = 1'b1;
    t_at = -1;
    for (int n = 1; n <= 105; n++) begin
      step();
      if (tick1 && t_at < 0) t_at = n;
    end
    check("first tick delay", 32'(t_at), 32'd100);
    frame("basic", 1'b0, 10, 'h3FF, 'h155, 1'b0, 1'b0, 1'b0);
    repeat (3) frame("rand", 1'b0, 10, int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)), 1'b0, 1'b0, 1'b0);
    frame("snapshot", 1'b0, 10, int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)), 1'b1, 1'b0, 1'b0);
    frame("en drop", 1'b0, 10, int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)), 1'b0, 1'b1, 1'b0);
    ticks = 0;
    repeat (250) begin step(); if (tick1) ticks++; end
    check("no tick while disabled", 32'(ticks), 32'd0);
    en1 = 1'b1;
    en2 = 1'b1;
    frame("width8", 1'b1, 8, 'hA5, int'($urandom_range(0, 255)), 1'b0, 1'b0, 1'b0);
    check("overrun set", 32'(ovr2), 32'd1);
    clr2 = 1'b1;
    step();
    clr2 = 1'b0;
    step();
    check("overrun cleared", 32'(ovr2), 32'd0);
    frame("set+clr", 1'b1, 8, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 1'b0, 1'b0, 1'b1);
    check("overrun set wins", 32'(ovr2), 32'd1);
    sel = 1'b0;
    wait_tick(200, ok);
    check("mid reset tick seen", 32'(ok), 32'd1);
    repeat (10) step();
    check("mid reset shifting", 32'(cs1), 32'h2);
    rst_n = 1'b0;
    step();
    check("mid reset cs", 32'(cs1), 32'h3);
    check("mid reset sck", 32'(sck1), 32'd0);
    check("mid reset ld", 32'(ld1), 32'd1);
    check("mid reset busy", 32'(busy1), 32'd0);
    rst_n = 1'b1;
    step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
